// File: rtl/mcu_el2_dccm_sram_sink_pkg.sv
// Shared types and helpers for the DCCM SRAM sink and its ECC error-injection logic.
package mcu_el2_dccm_sram_sink_pkg;

  // Widest data word the injection mask supports.
  localparam int unsigned InjMaskW = 64;

  typedef enum logic {InjIdle, InjArmed} dccm_inj_state_e;
  typedef enum logic {InjSbe, InjDbe} dccm_inj_mode_e;

  function automatic logic [InjMaskW-1:0] dccm_inj_mask(dccm_inj_mode_e mode);
    return (mode == InjDbe) ? {{(InjMaskW-2){1'b0}}, 2'b11} : {{(InjMaskW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mcu_el2_dccm_sram_sink_if.sv
// DCCM SRAM request/response bundle between the VeeR core (master) and the memory sink (slave).
interface mcu_el2_dccm_sram_sink_if #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned ECC_W     = 7,
  parameter int unsigned FDATA_W   = 39
);

  logic [NUM_BANKS-1:0]         dccm_clken;
  logic [NUM_BANKS-1:0]         dccm_wren_bank;
  logic [NUM_BANKS*ADDR_W-1:0]  dccm_addr_bank;
  logic [NUM_BANKS*FDATA_W-1:0] dccm_wr_data_bank;
  logic [NUM_BANKS*ECC_W-1:0]   dccm_wr_ecc_bank;
  logic [NUM_BANKS*FDATA_W-1:0] dccm_bank_dout;
  logic [NUM_BANKS*ECC_W-1:0]   dccm_bank_ecc;

  modport master (
    output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    input  dccm_bank_dout, dccm_bank_ecc
  );

  modport slave (
    input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    output dccm_bank_dout, dccm_bank_ecc
  );

endinterface

// File: rtl/mcu_el2_dccm_sram_sink_bank_ram.sv
// One single-port DCCM bank: synchronous write, registered read data, storage not reset.
module mcu_el2_dccm_sram_sink_bank_ram #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned FDATA_W = 39
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clken_i,
  input  logic               wren_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [FDATA_W-1:0] wdata_i,
  output logic [FDATA_W-1:0] dout_o
);

  logic [FDATA_W-1:0] mem_q [2**ADDR_W];
  logic [FDATA_W-1:0] dout_q, dout_d;

  always_ff @(posedge clk_i) begin
    if (clken_i && wren_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read data only moves on a read; writes and idle cycles hold the last word.
  always_comb begin
    dout_d = dout_q;
    if (clken_i && !wren_i) begin
      dout_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/mcu_el2_dccm_sram_sink.sv
// DCCM SRAM sink: NUM_BANKS independent banks plus a one-shot ECC error-injection FSM that
// corrupts the data bits of the next read returned by the armed bank.
module mcu_el2_dccm_sram_sink
  import mcu_el2_dccm_sram_sink_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ECC_W     = 7,
  parameter int unsigned FDATA_W   = 39,
  localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_l,
  mcu_el2_dccm_sram_sink_if.slave     dccm,
  input  logic                        inj_req,
  input  logic [BANK_W-1:0]           inj_bank,
  input  logic                        inj_mode,
  output logic                        inj_busy,
  output logic                        inj_done
);

  if ((NUM_BANKS < 2) || (NUM_BANKS > 8) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0) ||
      (FDATA_W != DATA_W + ECC_W) || (DATA_W < 2) || (DATA_W > InjMaskW) ||
      (ADDR_W < 1)) begin : gen_bad_params
    $fatal(1, "mcu_el2_dccm_sram_sink: unsupported parameter combination");
  end

  logic [NUM_BANKS-1:0] rd_en;
  logic [FDATA_W-1:0]   ram_dout [NUM_BANKS];
  logic [DATA_W-1:0]    flip_q   [NUM_BANKS];
  logic [DATA_W-1:0]    flip_d   [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : gen_bank
    logic unused_wr_hi;

    assign rd_en[b] = dccm.dccm_clken[b] & ~dccm.dccm_wren_bank[b];
    // Only the data field of the write bus is stored; check bits come from wr_ecc.
    assign unused_wr_hi = ^dccm.dccm_wr_data_bank[b*FDATA_W+DATA_W +: ECC_W];

    mcu_el2_dccm_sram_sink_bank_ram #(
      .ADDR_W  (ADDR_W),
      .FDATA_W (FDATA_W)
    ) u_bank_ram (
      .clk_i   (clk),
      .rst_ni  (rst_l),
      .clken_i (dccm.dccm_clken[b]),
      .wren_i  (dccm.dccm_wren_bank[b]),
      .addr_i  (dccm.dccm_addr_bank[b*ADDR_W +: ADDR_W]),
      .wdata_i ({dccm.dccm_wr_ecc_bank[b*ECC_W +: ECC_W],
                 dccm.dccm_wr_data_bank[b*FDATA_W +: DATA_W]}),
      .dout_o  (ram_dout[b])
    );

    assign dccm.dccm_bank_dout[b*FDATA_W +: FDATA_W] = ram_dout[b] ^ {{ECC_W{1'b0}}, flip_q[b]};
    assign dccm.dccm_bank_ecc[b*ECC_W +: ECC_W]      = ram_dout[b][FDATA_W-1:DATA_W];
  end

  dccm_inj_state_e   state_q, state_d;
  dccm_inj_mode_e    mode_q, mode_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fire;
  logic [InjMaskW-1:0] mask;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bank_d  = bank_q;
    fire    = 1'b0;
    case (state_q)
      InjIdle: begin
        if (inj_req) begin
          state_d = InjArmed;
          bank_d  = inj_bank;
          mode_d  = dccm_inj_mode_e'(inj_mode);
        end
      end
      InjArmed: begin
        if (rd_en[bank_q]) begin
          fire    = 1'b1;
          state_d = InjIdle;
        end
      end
      default: state_d = InjIdle;
    endcase
    busy_d = (state_d == InjArmed);
    done_d = fire;
  end

  // The flip pattern lives alongside each bank's dout so a corrupted word stays corrupted
  // while dout holds, and is cleared by that bank's next clean read.
  always_comb begin
    mask = dccm_inj_mask(mode_q);
    for (int b = 0; b < NUM_BANKS; b++) begin
      flip_d[b] = flip_q[b];
      if (rd_en[b]) begin
        flip_d[b] = (fire && (bank_q == BANK_W'(b))) ? mask[DATA_W-1:0] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= InjIdle;
      mode_q  <= InjSbe;
      bank_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        flip_q[b] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bank_q  <= bank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int b = 0; b < NUM_BANKS; b++) begin
        flip_q[b] <= flip_d[b];
      end
    end
  end

  assign inj_busy = busy_q;
  assign inj_done = done_q;

endmodule

// File: tb/tb_mcu_el2_dccm_sram_sink.sv
// Directed bench for the DCCM SRAM sink: bank read/write latency and ECC error injection.
module tb_mcu_el2_dccm_sram_sink;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 7;
  localparam int unsigned FW = 39;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       inj_req;
  logic [1:0] inj_bank;
  logic       inj_mode;
  logic       inj_busy;
  logic       inj_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mcu_el2_dccm_sram_sink_if #(
    .NUM_BANKS (NB),
    .ADDR_W    (AW),
    .ECC_W     (EW),
    .FDATA_W   (FW)
  ) bus ();

  mcu_el2_dccm_sram_sink #(
    .NUM_BANKS (NB),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .ECC_W     (EW),
    .FDATA_W   (FW)
  ) u_dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .dccm     (bus.slave),
    .inj_req  (inj_req),
    .inj_bank (inj_bank),
    .inj_mode (inj_mode),
    .inj_busy (inj_busy),
    .inj_done (inj_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dout(input int b);
    return 64'(bus.dccm_bank_dout[b*FW +: FW]);
  endfunction

  function automatic logic [63:0] ecc(input int b);
    return 64'(bus.dccm_bank_ecc[b*EW +: EW]);
  endfunction

  task automatic set_bank(input int b, input logic ce, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [EW-1:0] e);
    bus.dccm_clken[b]                 = ce;
    bus.dccm_wren_bank[b]             = we;
    bus.dccm_addr_bank[b*AW +: AW]    = a;
    bus.dccm_wr_data_bank[b*FW +: FW] = {7'h7F, d};
    bus.dccm_wr_ecc_bank[b*EW +: EW]  = e;
  endtask

  task automatic idle_all();
    bus.dccm_clken     = '0;
    bus.dccm_wren_bank = '0;
    inj_req            = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random activity on every input
    bus.dccm_clken        = NB'($urandom);
    bus.dccm_wren_bank    = NB'($urandom);
    bus.dccm_addr_bank    = (NB*AW)'({$urandom, $urandom});
    bus.dccm_wr_data_bank = (NB*FW)'({$urandom, $urandom, $urandom, $urandom, $urandom});
    bus.dccm_wr_ecc_bank  = (NB*EW)'($urandom);
    inj_req  = 1'b1;
    inj_bank = 2'($urandom);
    inj_mode = 1'($urandom);
    tick();
    tick();
    tick();
    for (int b = 0; b < NB; b++) chk($sformatf("rst_dout%0d", b), dout(b), 64'h0);
    chk("rst_ecc_all", 64'(bus.dccm_bank_ecc), 64'h0);
    chk("rst_busy", 64'(inj_busy), 64'h0);
    chk("rst_done", 64'(inj_done), 64'h0);
    idle_all();
    rst_l = 1'b1;
    tick();
    tick();
    for (int b = 0; b < NB; b++) chk($sformatf("post_rst_dout%0d", b), dout(b), 64'h0);
    chk("post_rst_busy", 64'(inj_busy), 64'h0);

    // Bank0 write then read: write cycle holds dout, read lands one cycle later
    set_bank(0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 7'h5A);
    tick();
    chk("b0_write_hold", dout(0), 64'h0);
    set_bank(0, 1'b1, 1'b0, 12'h010, 32'h0, 7'h0);
    tick();
    chk("b0_read_dout", dout(0), 64'h5A_DEADBEEF);
    chk("b0_read_ecc", ecc(0), 64'h5A);
    idle_all();

    // All banks write, then all read, in the same cycle
    for (int b = 0; b < NB; b++) set_bank(b, 1'b1, 1'b1, 12'(32'h020 + b), 32'hA0A0_0000 | b,
                                          7'(32'h10 + b));
    tick();
    for (int b = 0; b < NB; b++) set_bank(b, 1'b1, 1'b0, 12'(32'h020 + b), 32'h0, 7'h0);
    tick();
    chk("all_dout0", dout(0), 64'h10_A0A00000);
    chk("all_dout1", dout(1), 64'h11_A0A00001);
    chk("all_dout2", dout(2), 64'h12_A0A00002);
    chk("all_dout3", dout(3), 64'h13_A0A00003);
    chk("all_ecc1", ecc(1), 64'h11);
    chk("all_ecc3", ecc(3), 64'h13);
    // clken low with wren high: dout holds, write ignored
    for (int b = 0; b < NB; b++) set_bank(b, 1'b0, 1'b1, 12'h020, 32'h5555_5555, 7'h55);
    tick();
    chk("hold_dout0", dout(0), 64'h10_A0A00000);
    chk("hold_dout3", dout(3), 64'h13_A0A00003);
    set_bank(0, 1'b1, 1'b0, 12'h020, 32'h0, 7'h0);
    bus.dccm_clken[3:1] = 3'b000;
    tick();
    chk("noclken_nowrite", dout(0), 64'h10_A0A00000);
    idle_all();

    // Single-bit injection on bank2; a write must not fire it
    inj_req  = 1'b1;
    inj_bank = 2'd2;
    inj_mode = 1'b0;
    tick();
    inj_req = 1'b0;
    chk("sbe_busy_armed", 64'(inj_busy), 64'h1);
    set_bank(2, 1'b1, 1'b1, 12'h030, 32'h0000_0010, 7'h22);
    tick();
    chk("sbe_write_nofire_busy", 64'(inj_busy), 64'h1);
    chk("sbe_write_nofire_done", 64'(inj_done), 64'h0);
    set_bank(2, 1'b1, 1'b0, 12'h030, 32'h0, 7'h0);
    tick();
    chk("sbe_dout", dout(2), 64'h22_00000011);
    chk("sbe_ecc", ecc(2), 64'h22);
    chk("sbe_done", 64'(inj_done), 64'h1);
    chk("sbe_busy_clear", 64'(inj_busy), 64'h0);
    idle_all();
    tick();
    chk("sbe_done_pulse", 64'(inj_done), 64'h0);
    chk("sbe_dout_hold", dout(2), 64'h22_00000011);
    set_bank(2, 1'b1, 1'b0, 12'h030, 32'h0, 7'h0);
    tick();
    chk("sbe_reread", dout(2), 64'h22_00000010);
    idle_all();

    // Double-bit injection armed coincident with a bank1 read
    set_bank(1, 1'b1, 1'b1, 12'h040, 32'hFFFF_FFFF, 7'h33);
    tick();
    set_bank(1, 1'b1, 1'b0, 12'h040, 32'h0, 7'h0);
    inj_req  = 1'b1;
    inj_bank = 2'd1;
    inj_mode = 1'b1;
    tick();
    chk("dbe_coincident_clean", dout(1), 64'h33_FFFFFFFF);
    chk("dbe_coincident_done", 64'(inj_done), 64'h0);
    chk("dbe_busy", 64'(inj_busy), 64'h1);
    // Second request while armed must not re-target bank0
    idle_all();
    inj_req  = 1'b1;
    inj_bank = 2'd0;
    inj_mode = 1'b0;
    tick();
    inj_req = 1'b0;
    set_bank(0, 1'b1, 1'b0, 12'h010, 32'h0, 7'h0);
    tick();
    chk("dbe_relatch_b0_clean", dout(0), 64'h5A_DEADBEEF);
    chk("dbe_relatch_nodone", 64'(inj_done), 64'h0);
    idle_all();
    set_bank(1, 1'b1, 1'b0, 12'h040, 32'h0, 7'h0);
    tick();
    chk("dbe_dout", dout(1), 64'h33_FFFFFFFC);
    chk("dbe_done", 64'(inj_done), 64'h1);
    idle_all();

    // Reset while armed drops the pending injection
    set_bank(3, 1'b1, 1'b1, 12'h050, 32'h1234_5678, 7'h44);
    tick();
    idle_all();
    inj_req  = 1'b1;
    inj_bank = 2'd3;
    inj_mode = 1'b0;
    tick();
    inj_req = 1'b0;
    chk("rst_arm_busy", 64'(inj_busy), 64'h1);
    #3 rst_l = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(inj_busy), 64'h0);
    chk("rst_mid_dout0", dout(0), 64'h0);
    #2 rst_l = 1'b1;
    tick();
    set_bank(3, 1'b1, 1'b0, 12'h050, 32'h0, 7'h0);
    tick();
    chk("rst_b3_clean", dout(3), 64'h44_12345678);
    chk("rst_b3_nodone", 64'(inj_done), 64'h0);
    idle_all();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
